// File: rtl/status_flag_unit_pkg.sv
// Shared definitions for the status flag unit: ALU command codes, flag bit
// positions and the packed status word type.
`default_nettype none

package status_flag_unit_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam int C_IDX = 3;
  localparam int N_IDX = 2;
  localparam int V_IDX = 1;
  localparam int Z_IDX = 0;

  typedef logic [3:0] status_t;

endpackage

`default_nettype wire

// File: rtl/status_flag_unit_flag_gen.sv
// Combinational ALU result and raw {c, n, v, z} flags for one command.
`default_nettype none

module flag_gen
  import status_flag_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output status_t          flags,
  output logic             arith
);

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;

  always_comb begin
    b_eff = val_b;
    cin   = 1'b0;
    arith = 1'b0;
    case (exe_cmd)
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin arith = 1'b1; cin = carry_in; end
      CMD_SUB: begin arith = 1'b1; b_eff = ~val_b; cin = 1'b1; end
      CMD_SBC: begin arith = 1'b1; b_eff = ~val_b; cin = carry_in; end
      default: ;
    endcase
  end

  assign sum = {1'b0, val_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    result = '0;
    case (exe_cmd)
      CMD_MOV: result = val_b;
      CMD_MVN: result = ~val_b;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: result = sum[WIDTH-1:0];
      CMD_AND: result = val_a & val_b;
      CMD_ORR: result = val_a | val_b;
      CMD_EOR: result = val_a ^ val_b;
      default: result = '0;
    endcase
  end

  // For logical commands c/v here are placeholders; the caller retains its own.
  always_comb begin
    flags        = '0;
    flags[N_IDX] = result[WIDTH-1];
    flags[Z_IDX] = (result == '0);
    flags[C_IDX] = arith ? sum[WIDTH] : carry_in;
    flags[V_IDX] = arith & (val_a[WIDTH-1] == b_eff[WIDTH-1])
                         & (result[WIDTH-1] != val_a[WIDTH-1]);
  end

endmodule

`default_nettype wire

// File: rtl/status_flag_unit.sv
// Execute-stage status register with same-cycle bypass and a one-entry
// exception shadow.
`default_nettype none

module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic             s_update,
  input  logic             stall,
  input  logic             flush,
  input  logic             save,
  input  logic             restore,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       status_register,
  output logic [3:0]       status_next,
  output logic [3:0]       saved_status
);

  status_t status_q;
  status_t shadow_q;
  status_t shadow_next;
  status_t gen_flags;
  status_t new_flags;
  logic    arith;
  logic    we;

  flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .exe_cmd  (exe_cmd),
    .val_a    (val_a),
    .val_b    (val_b),
    .carry_in (status_q[C_IDX]),
    .result   (alu_result),
    .flags    (gen_flags),
    .arith    (arith)
  );

  always_comb begin
    new_flags = gen_flags;
    if (!arith) begin
      new_flags[C_IDX] = status_q[C_IDX];
      new_flags[V_IDX] = status_q[V_IDX];
    end
  end

  assign we = valid & s_update & ~stall & ~flush;

  // Shadow captures the pre-update status even when restore/we also fire.
  always_comb begin
    status_next = status_q;
    shadow_next = shadow_q;
    if (!stall) begin
      if (restore)  status_next = shadow_q;
      else if (we)  status_next = new_flags;
      if (save)     shadow_next = status_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      shadow_q <= '0;
    end else begin
      status_q <= status_next;
      shadow_q <= shadow_next;
    end
  end

  assign status_register = status_q;
  assign saved_status    = shadow_q;

endmodule

`default_nettype wire

// File: tb/tb_status_flag_unit.sv
// Scoreboard bench for status_flag_unit: directed corner cases plus random
// traffic checked against an arithmetic reference model.
`default_nettype none

module tb_status_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  exe_cmd = '0;
  logic [31:0] val_a = '0;
  logic [31:0] val_b = '0;
  logic        s_update = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        save = 1'b0;
  logic        restore = 1'b0;
  logic [31:0] alu_result;
  logic [3:0]  status_register;
  logic [3:0]  status_next;
  logic [3:0]  saved_status;

  status_flag_unit #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid           (valid),
    .exe_cmd         (exe_cmd),
    .val_a           (val_a),
    .val_b           (val_b),
    .s_update        (s_update),
    .stall           (stall),
    .flush           (flush),
    .save            (save),
    .restore         (restore),
    .alu_result      (alu_result),
    .status_register (status_register),
    .status_next     (status_next),
    .saved_status    (saved_status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  nxt;
    logic [3:0]  st;
    logic [3:0]  sh;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  m_st = 4'b0;
  logic [3:0]  m_sh = 4'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: flags from signed/unsigned integer arithmetic, status packed {c,n,v,z}.
  task automatic model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] cur, output logic [31:0] r, output logic [3:0] f);
    longint sa, sb, sr;
    longint unsigned ua, ub, cin;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    cin = {63'b0, cur[3]};
    c = cur[3];
    v = cur[1];
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b;
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      4'b0010, 4'b0011: begin
        if (cmd == 4'b0010) cin = 0;
        r  = 32'(ua + ub + cin);
        c  = (ua + ub + cin) > 64'hFFFF_FFFF;
        sr = sa + sb + longint'(cin);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'b0100, 4'b0101: begin
        if (cmd == 4'b0100) cin = 1;
        r  = 32'(ua - ub - 1 + cin);
        c  = (ua + cin) >= (ub + 1);
        sr = sa - sb - 1 + longint'(cin);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      default: r = 32'h0;
    endcase
    f = {c, r[31], v, (r == 32'h0)};
  endtask

  task automatic step(input logic v, input logic [3:0] cmd, input logic [31:0] a,
                      input logic [31:0] b, input logic s, input logic st, input logic fl,
                      input logic sv, input logic rs);
    logic [31:0] r;
    logic [3:0]  f, nxt;
    exp_t        e;
    @(posedge clk);
    #1;
    valid = v; exe_cmd = cmd; val_a = a; val_b = b; s_update = s;
    stall = st; flush = fl; save = sv; restore = rs;
    model(cmd, a, b, m_st, r, f);
    nxt = m_st;
    if (!st) begin
      if (rs) nxt = m_sh;
      else if (v && s && !fl) nxt = f;
    end
    e.res = r; e.nxt = nxt; e.st = m_st; e.sh = m_sh;
    q.push_back(e);
    if (!st && sv) m_sh = m_st;
    m_st = nxt;
  endtask

  task automatic op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                    input logic s);
    step(1'b1, cmd, a, b, s, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compare every scheduled expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("alu_result", alu_result, e.res);
        chk("status_next", {28'b0, status_next}, {28'b0, e.nxt});
        chk("status_register", {28'b0, status_register}, {28'b0, e.st});
        chk("saved_status", {28'b0, saved_status}, {28'b0, e.sh});
      end
    end
  end

  initial begin
    #2;
    chk("reset_status", {28'b0, status_register}, 32'h0);
    chk("reset_saved", {28'b0, saved_status}, 32'h0);
    #21 rst_n = 1'b1;

    // Signed overflow into negative, then equality and borrow subtracts.
    op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1);
    op(4'b0100, 32'd5, 32'd5, 1'b1);
    op(4'b0100, 32'd3, 32'd5, 1'b1);
    // Build c=1,v=1 then logical ops keep them.
    op(4'b0010, 32'h8000_0000, 32'h8000_0001, 1'b1);
    op(4'b0110, 32'hF0, 32'h0F, 1'b1);
    op(4'b0110, 32'hF0, 32'h0F, 1'b0);
    // Carry-consuming add with stall for two cycles, then flushed copy.
    op(4'b0100, 32'd5, 32'd5, 1'b1);
    step(1'b1, 4'b0011, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 4'b0011, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    op(4'b0011, 32'hFFFF_FFFF, 32'h0, 1'b1);
    step(1'b1, 4'b0010, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Save during a flag-setting ADD, then restore beside a SUB.
    step(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    op(4'b0100, 32'd1, 32'd9, 1'b1);
    step(1'b1, 4'b0100, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    op(4'b1111, 32'h1234, 32'h5678, 1'b1);
    op(4'b1001, 32'h0, 32'h0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), pick(), pick(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0);
      if (i == 200) begin
        @(posedge clk);
        #1;
        valid = 1'b0; save = 1'b1; restore = 1'b1; stall = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset_status", {28'b0, status_register}, 32'h0);
        chk("async_reset_saved", {28'b0, saved_status}, 32'h0);
        m_st = 4'b0;
        m_sh = 4'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        save = 1'b0; restore = 1'b0;
        op(4'b0001, 32'h0, 32'h0, 1'b1);
      end
    end

    step(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
